// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_program_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = WORD_BYTES * 8;

  // True while a program image is in flight (core must stay in reset)
  function automatic logic is_loading(state_t s);
    return (s == ST_HDR) || (s == ST_COLLECT) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_program_loader_if;
  import imem_program_loader_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_wen;
  logic [WORD_W-1:0] mem_add;
  logic [WORD_W-1:0] mem_ina;

  // Host side: drives the stream, observes the memory write port
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_wen, mem_add, mem_ina
  );

  // Loader side
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_wen, mem_add, mem_ina
  );
endinterface

// File: rtl/loader_idle_timer.sv
// Counts consecutive idle cycles; expire flags the TIMEOUT-th idle cycle.
module loader_idle_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  // Idle cycle counter; clear has priority over counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // The current idle cycle is the TIMEOUT-th one in a row
  assign expire = enable && (count_reg == CW'(TIMEOUT - 1));
endmodule

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit
// little-endian words, holding the core in reset while loading.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int MEM_BYTES  = 64,
  parameter int START_ADDR = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  imem_program_loader_if.slave bus,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           words_written
);
  localparam logic [8:0]        MAX_WORDS  = 9'(MEM_BYTES / WORD_BYTES);
  localparam logic [WORD_W-1:0] ADDR_MASK  = WORD_W'(MEM_BYTES - 1);
  localparam logic [WORD_W-1:0] START_WORD = WORD_W'(START_ADDR);

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] addr_reg;
  logic [WORD_W-1:0] mem_add_reg;
  logic [WORD_W-1:0] mem_ina_reg;
  logic [1:0]        byte_idx_reg;
  logic [7:0]        remaining_reg;
  logic [7:0]        words_written_reg;

  logic accepting;
  logic xfer;
  logic hdr_bad;
  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  assign accepting = (state_reg == ST_HDR) || (state_reg == ST_COLLECT);
  assign xfer      = bus.rx_valid && accepting;
  assign hdr_bad   = (bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > MAX_WORDS);

  // Outside HDR/COLLECT the timer is held at zero, so HDR entry starts fresh
  assign timer_clear  = xfer || !accepting;
  assign timer_enable = accepting && !xfer;

  loader_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_next   = state_reg;
    bus.rx_ready = 1'b0;
    bus.mem_wen  = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_HDR;
      end
      ST_HDR: begin
        bus.rx_ready = 1'b1;
        if (timer_expire) state_next = ST_ERR;
        else if (xfer)    state_next = hdr_bad ? ST_ERR : ST_COLLECT;
      end
      ST_COLLECT: begin
        bus.rx_ready = 1'b1;
        if (timer_expire)                       state_next = ST_ERR;
        else if (xfer && byte_idx_reg == 2'd3)  state_next = ST_WRITE;
      end
      ST_WRITE: begin
        bus.mem_wen = 1'b1;
        state_next  = (remaining_reg == 8'd1) ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) state_next = ST_HDR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy          = is_loading(state_reg);
  assign cpu_hold      = is_loading(state_reg);
  assign bus.mem_add   = mem_add_reg;
  assign bus.mem_ina   = mem_ina_reg;
  assign words_written = words_written_reg;

  // Word assembly, address/count tracking and the write-port holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_reg          <= '0;
      addr_reg          <= '0;
      mem_add_reg       <= '0;
      mem_ina_reg       <= '0;
      byte_idx_reg      <= '0;
      remaining_reg     <= '0;
      words_written_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            addr_reg          <= START_WORD;
            words_written_reg <= '0;
            word_reg          <= '0;
            byte_idx_reg      <= '0;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            remaining_reg <= bus.rx_data;
            byte_idx_reg  <= '0;
          end
        end
        ST_COLLECT: begin
          if (xfer) begin
            // Shift in from the top so byte 0 ends up in [7:0]
            word_reg     <= {bus.rx_data, word_reg[WORD_W-1:8]};
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              mem_ina_reg <= {bus.rx_data, word_reg[WORD_W-1:8]};
              mem_add_reg <= addr_reg;
            end
          end
        end
        ST_WRITE: begin
          words_written_reg <= words_written_reg + 8'd1;
          addr_reg          <= (addr_reg + WORD_W'(WORD_BYTES)) & ADDR_MASK;
          remaining_reg     <= remaining_reg - 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench: two loader instances (default placement, and one that
// starts at the top of memory with a short idle timeout).
module tb_imem_program_loader;
  localparam int TO_A = 1024;
  localparam int TO_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic       cpu_hold_a, busy_a, done_a, err_a;
  logic       cpu_hold_b, busy_b, done_b, err_b;
  logic [7:0] ww_a, ww_b;

  imem_program_loader_if bus_a();
  imem_program_loader_if bus_b();

  imem_program_loader #(.MEM_BYTES(64), .START_ADDR(0), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a),
    .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .err(err_a),
    .words_written(ww_a)
  );

  imem_program_loader #(.MEM_BYTES(64), .START_ADDR(60), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b),
    .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .err(err_b),
    .words_written(ww_b)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [31:0] wr_addr_a[$], wr_data_a[$], wr_addr_b[$], wr_data_b[$];

  // Record memory writes and done pulses mid-cycle
  always @(negedge clk) begin
    if (bus_a.mem_wen === 1'b1) begin
      wr_addr_a.push_back(bus_a.mem_add);
      wr_data_a.push_back(bus_a.mem_ina);
      $display("write A: addr=%0d data=%h", bus_a.mem_add, bus_a.mem_ina);
    end
    if (bus_b.mem_wen === 1'b1) begin
      wr_addr_b.push_back(bus_b.mem_add);
      wr_data_b.push_back(bus_b.mem_ina);
      $display("write B: addr=%0d data=%h", bus_b.mem_add, bus_b.mem_ina);
    end
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Idle for gap cycles, then present byte b until the loader takes it
  task automatic send_byte(input int which, input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    if (which == 0) bus_a.rx_valid = 1'b0; else bus_b.rx_valid = 1'b0;
    repeat (gap) tick();
    if (which == 0) begin bus_a.rx_data = b; bus_a.rx_valid = 1'b1; end
    else            begin bus_b.rx_data = b; bus_b.rx_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      if (!got) begin
        if ((which == 0 && bus_a.rx_ready === 1'b1) ||
            (which == 1 && bus_b.rx_ready === 1'b1)) got = 1'b1;
        tick();
      end
    end
    check("byte_accepted", {31'b0, got}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    bus_a.rx_data = 8'h00; bus_a.rx_valid = 1'b0;
    bus_b.rx_data = 8'h00; bus_b.rx_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_cpu_hold", cpu_hold_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_words", ww_a, 0);
    check("rst_mem_wen", bus_a.mem_wen, 0);
    check("rst_mem_add", bus_a.mem_add, 0);
    check("rst_mem_ina", bus_a.mem_ina, 0);
    check("rst_rx_ready", bus_a.rx_ready, 0);
    rst_n = 1'b1;
    tick();

    // Two-word load, continuous valid, start held while busy
    start_a = 1'b1;
    tick();
    check("t1_busy", busy_a, 1);
    check("t1_hold", cpu_hold_a, 1);
    check("t1_ready_hdr", bus_a.rx_ready, 1);
    send_byte(0, 8'h02, 0);
    start_a = 1'b0;
    check("t1_busy_collect", busy_a, 1);
    send_byte(0, 8'hEF, 0);
    send_byte(0, 8'hBE, 0);
    send_byte(0, 8'hAD, 0);
    send_byte(0, 8'hDE, 0);
    check("t1_w0_wen", bus_a.mem_wen, 1);
    check("t1_w0_add", bus_a.mem_add, 32'd0);
    check("t1_w0_ina", bus_a.mem_ina, 32'hDEADBEEF);
    check("t1_w0_ready", bus_a.rx_ready, 0);
    check("t1_w0_words", ww_a, 0);
    send_byte(0, 8'h78, 0);
    send_byte(0, 8'h56, 0);
    send_byte(0, 8'h34, 0);
    send_byte(0, 8'h12, 0);
    check("t1_w1_wen", bus_a.mem_wen, 1);
    check("t1_w1_add", bus_a.mem_add, 32'd4);
    check("t1_w1_ina", bus_a.mem_ina, 32'h12345678);
    check("t1_w1_words", ww_a, 1);
    bus_a.rx_valid = 1'b0;
    start_a = 1'b1;                       // arrives in the DONE cycle
    tick();
    check("t1_done", done_a, 1);
    check("t1_done_hold", cpu_hold_a, 0);
    check("t1_done_busy", busy_a, 0);
    check("t1_done_words", ww_a, 2);
    check("t1_done_wen", bus_a.mem_wen, 0);
    tick();
    check("t1_idle_busy", busy_a, 0);
    check("t1_idle_done", done_a, 0);
    check("t1_idle_add", bus_a.mem_add, 32'd4);
    check("t1_idle_ina", bus_a.mem_ina, 32'h12345678);
    tick();
    start_a = 1'b0;
    check("t1_restart_busy", busy_a, 1);
    check("t1_restart_words", ww_a, 0);
    check("t1_nwrites", wr_addr_a.size(), 2);
    check("t1_wr0_add", wr_addr_a[0], 32'd0);
    check("t1_wr0_dat", wr_data_a[0], 32'hDEADBEEF);
    check("t1_wr1_add", wr_addr_a[1], 32'd4);
    check("t1_wr1_dat", wr_data_a[1], 32'h12345678);
    check("t1_done_pulses", done_cnt_a, 1);

    // Bad headers
    send_byte(0, 8'h00, 0);
    bus_a.rx_valid = 1'b0;
    check("t2_err_zero", err_a, 1);
    check("t2_hold", cpu_hold_a, 0);
    check("t2_busy", busy_a, 0);
    check("t2_ready", bus_a.rx_ready, 0);
    tick();
    check("t2_err_sticky", err_a, 1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t2_err_cleared", err_a, 0);
    send_byte(0, 8'h11, 0);
    bus_a.rx_valid = 1'b0;
    check("t2_err_17", err_a, 1);
    check("t2_nwrites", wr_addr_a.size(), 2);

    // Gaps of 5 idle cycles between bytes
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t4_err_cleared", err_a, 0);
    send_byte(0, 8'h01, 5);
    send_byte(0, 8'hAA, 5);
    send_byte(0, 8'hBB, 5);
    send_byte(0, 8'hCC, 5);
    send_byte(0, 8'hDD, 5);
    bus_a.rx_valid = 1'b0;
    check("t4_wen", bus_a.mem_wen, 1);
    check("t4_add", bus_a.mem_add, 32'd0);
    check("t4_ina", bus_a.mem_ina, 32'hDDCCBBAA);
    tick();
    check("t4_done", done_a, 1);
    check("t4_words", ww_a, 1);
    tick();

    // Idle timeout mid-word
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send_byte(0, 8'h02, 0);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    bus_a.rx_valid = 1'b0;
    repeat (TO_A - 1) tick();
    check("t4_to_before_err", err_a, 0);
    check("t4_to_before_busy", busy_a, 1);
    tick();
    check("t4_to_err", err_a, 1);
    check("t4_to_busy", busy_a, 0);
    check("t4_to_nwrites", wr_addr_a.size(), 3);
    check("t4_to_done_pulses", done_cnt_a, 2);

    // Reset in the middle of a word
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'hAA, 0);
    send_byte(0, 8'hBB, 0);
    bus_a.rx_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t5_busy", busy_a, 0);
    check("t5_hold", cpu_hold_a, 0);
    check("t5_err", err_a, 0);
    check("t5_done", done_a, 0);
    check("t5_wen", bus_a.mem_wen, 0);
    check("t5_add", bus_a.mem_add, 0);
    check("t5_ina", bus_a.mem_ina, 0);
    check("t5_words", ww_a, 0);
    check("t5_ready", bus_a.rx_ready, 0);
    rst_n = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h02, 0);
    send_byte(0, 8'h03, 0);
    send_byte(0, 8'h04, 0);
    bus_a.rx_valid = 1'b0;
    check("t5_fresh_add", bus_a.mem_add, 32'd0);
    check("t5_fresh_ina", bus_a.mem_ina, 32'h04030201);
    tick();
    check("t5_fresh_done", done_a, 1);
    tick();
    check("t5_nwrites", wr_addr_a.size(), 4);
    check("t5_done_pulses", done_cnt_a, 3);

    // Address wrap from the top of memory
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    send_byte(1, 8'h02, 0);
    send_byte(1, 8'h11, 0);
    send_byte(1, 8'h22, 0);
    send_byte(1, 8'h33, 0);
    send_byte(1, 8'h44, 0);
    check("t3_w0_add", bus_b.mem_add, 32'd60);
    check("t3_w0_ina", bus_b.mem_ina, 32'h44332211);
    send_byte(1, 8'h55, 0);
    send_byte(1, 8'h66, 0);
    send_byte(1, 8'h77, 0);
    send_byte(1, 8'h88, 0);
    bus_b.rx_valid = 1'b0;
    check("t3_w1_add", bus_b.mem_add, 32'd0);
    check("t3_w1_ina", bus_b.mem_ina, 32'h88776655);
    check("t3_w1_align", bus_b.mem_add & 32'd3, 32'd0);
    tick();
    check("t3_done", done_b, 1);
    check("t3_words", ww_b, 2);
    tick();
    check("t3_nwrites", wr_addr_b.size(), 2);
    check("t3_wr0_add", wr_addr_b[0], 32'd60);
    check("t3_wr1_add", wr_addr_b[1], 32'd0);
    check("t3_done_pulses", done_cnt_b, 1);

    // Largest legal header (16 words) is accepted, then short timeout fires
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    send_byte(1, 8'h10, 0);
    bus_b.rx_valid = 1'b0;
    check("t3_max_hdr_err", err_b, 0);
    check("t3_max_hdr_ready", bus_b.rx_ready, 1);
    repeat (TO_B - 1) tick();
    check("t3_to_before", err_b, 0);
    tick();
    check("t3_to_err", err_b, 1);
    check("t3_to_nwrites", wr_addr_b.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
